// File: rtl/mma_pkg.sv
// Shared types and defaults for the matrix-multiply operand bank.
package mma_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int MAX_DIM_DEF = 3;
  localparam int DIM_W_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_LOAD_X = 3'd3,
    ST_CLR    = 3'd4,
    ST_STREAM = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Read-port mode: W is read by column, X by row.
  localparam logic RD_COL = 1'b0;
  localparam logic RD_ROW = 1'b1;

endpackage

// File: rtl/mma_operand_store.sv
// Flat MAX_DIM x MAX_DIM operand store: one write port, synchronous clear,
// and a MAX_DIM-lane read port returning either a column or a row.
module mma_operand_store
  import mma_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int SEL_W   = DIM_W_DEF,
  parameter int ADDR_W  = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      rd_mode,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [MAX_DIM*DATA_W-1:0] rd_data
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Next-state of the storage array: clear beats write.
  always_comb begin
    mem_d = mem_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Lane i is element (sel, i) for a row read, (i, sel) for a column read.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (rd_mode == RD_ROW) begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[ADDR_W'(int'(rd_sel) * MAX_DIM + i)];
      end else begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[ADDR_W'(i * MAX_DIM + int'(rd_sel))];
      end
    end
  end

endmodule

// File: rtl/mma_operand_bank.sv
// Operand bank: loads W then X from one stream, then streams outer-product beats.
// Define MMA_STREAM_BP_EN to add the out_ready backpressure port on the beat stream.
module mma_operand_bank
  import mma_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int DIM_W   = DIM_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_mem,
  input  logic                      start,
  input  logic [DIM_W-1:0]          row_w,
  input  logic [DIM_W-1:0]          col_w,
  input  logic [DIM_W-1:0]          row_x,
  input  logic [DIM_W-1:0]          col_x,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [MAX_DIM*DATA_W-1:0] data_outw,
  output logic [MAX_DIM*DATA_W-1:0] data_outx,
  output logic                      ld_mac,
  output logic                      clear_mac,
`ifdef MMA_STREAM_BP_EN
  input  logic                      out_ready,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      dim_err
);

  localparam int ADDR_W = $clog2(MAX_DIM * MAX_DIM);
  localparam int LANE_W = MAX_DIM * DATA_W;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  row_w_q, col_w_q, row_x_q, col_x_q;
  logic [DIM_W-1:0]  row_w_d, col_w_d, row_x_d, col_x_d;
  logic [DIM_W-1:0]  r_q, c_q, k_q, r_d, c_d, k_d;
  logic              dim_err_q, dim_err_d;
  logic              ld_ready_q, ld_ready_d, busy_q, busy_d, done_q, done_d;
  logic              clear_mac_q, clear_mac_d, ld_mac_q, ld_mac_d;
  logic [LANE_W-1:0] outw_q, outw_d, outx_q, outx_d;

  logic              accept_s, beat_adv_s, last_elem_s, dims_bad_s;
  logic [DIM_W-1:0]  ld_rows_s, ld_cols_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [LANE_W-1:0] w_rd_s, x_rd_s;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != DIM_W'(0)) && (int'(d) <= MAX_DIM);
  endfunction

  assign accept_s = ld_valid && ld_ready_q;
`ifdef MMA_STREAM_BP_EN
  assign beat_adv_s = ld_mac_q && out_ready;
`else
  assign beat_adv_s = ld_mac_q;
`endif
  assign ld_rows_s   = (state_q == ST_LOAD_W) ? row_w_q : row_x_q;
  assign ld_cols_s   = (state_q == ST_LOAD_W) ? col_w_q : col_x_q;
  assign last_elem_s = (r_q == ld_rows_s - DIM_W'(1)) && (c_q == ld_cols_s - DIM_W'(1));
  assign dims_bad_s  = !dim_ok(row_w_q) || !dim_ok(col_w_q) || !dim_ok(row_x_q) ||
                       !dim_ok(col_x_q) || (col_w_q != row_x_q);
  // Constant stride keeps the address independent of the loaded column count.
  assign waddr_s     = ADDR_W'(int'(r_q) * MAX_DIM + int'(c_q));

  mma_operand_store #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .SEL_W(DIM_W)) u_store_w (
    .clk(clk), .rst_n(rst_n), .clear(clear_mem),
    .we(accept_s && (state_q == ST_LOAD_W)), .waddr(waddr_s), .wdata(ld_data),
    .rd_mode(RD_COL), .rd_sel(k_d), .rd_data(w_rd_s)
  );

  mma_operand_store #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .SEL_W(DIM_W)) u_store_x (
    .clk(clk), .rst_n(rst_n), .clear(clear_mem),
    .we(accept_s && (state_q == ST_LOAD_X)), .waddr(waddr_s), .wdata(ld_data),
    .rd_mode(RD_ROW), .rd_sel(k_d), .rd_data(x_rd_s)
  );

  // Next-state: FSM, latched dimensions, load/beat indices, sticky error.
  always_comb begin
    state_d   = state_q;
    row_w_d   = row_w_q;
    col_w_d   = col_w_q;
    row_x_d   = row_x_q;
    col_x_d   = col_x_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    dim_err_d = dim_err_q;
    if (clear_mem) begin
      state_d   = ST_IDLE;
      r_d       = '0;
      c_d       = '0;
      k_d       = '0;
      dim_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_w_d   = row_w;
            col_w_d   = col_w;
            row_x_d   = row_x;
            col_x_d   = col_x;
            dim_err_d = 1'b0;
            state_d   = ST_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHECK: begin
          r_d = '0;
          c_d = '0;
          if (dims_bad_s) begin
            dim_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_LOAD_W;
          end
        end
        ST_LOAD_W, ST_LOAD_X: begin
          if (accept_s) begin
            if (last_elem_s) begin
              r_d     = '0;
              c_d     = '0;
              state_d = (state_q == ST_LOAD_W) ? ST_LOAD_X : ST_CLR;
            end else if (c_q == ld_cols_s - DIM_W'(1)) begin
              c_d = '0;
              r_d = r_q + DIM_W'(1);
            end else begin
              c_d = c_q + DIM_W'(1);
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_CLR: begin
          k_d     = '0;
          state_d = ST_STREAM;
        end
        ST_STREAM: begin
          if (beat_adv_s) begin
            if (k_q == col_w_q - DIM_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              k_d = k_q + DIM_W'(1);
            end
          end else begin
            k_d = k_q;
          end
        end
        ST_DONE: begin
          k_d     = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state; idle/unused lanes forced to zero.
  always_comb begin
    ld_ready_d  = (state_d == ST_LOAD_W) || (state_d == ST_LOAD_X);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    clear_mac_d = (state_d == ST_CLR);
    ld_mac_d    = (state_d == ST_STREAM);
    outw_d      = '0;
    outx_d      = '0;
    if (ld_mac_d) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        if (i < int'(row_w_q)) begin
          outw_d[i*DATA_W +: DATA_W] = w_rd_s[i*DATA_W +: DATA_W];
        end else begin
          outw_d[i*DATA_W +: DATA_W] = '0;
        end
        if (i < int'(col_x_q)) begin
          outx_d[i*DATA_W +: DATA_W] = x_rd_s[i*DATA_W +: DATA_W];
        end else begin
          outx_d[i*DATA_W +: DATA_W] = '0;
        end
      end
    end else begin
      outw_d = '0;
      outx_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_w_q     <= '0;
      col_w_q     <= '0;
      row_x_q     <= '0;
      col_x_q     <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      dim_err_q   <= 1'b0;
      ld_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_mac_q <= 1'b0;
      ld_mac_q    <= 1'b0;
      outw_q      <= '0;
      outx_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_w_q     <= row_w_d;
      col_w_q     <= col_w_d;
      row_x_q     <= row_x_d;
      col_x_q     <= col_x_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      dim_err_q   <= dim_err_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clear_mac_q <= clear_mac_d;
      ld_mac_q    <= ld_mac_d;
      outw_q      <= outw_d;
      outx_q      <= outx_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dim_err   = dim_err_q;
  assign clear_mac = clear_mac_q;
  assign ld_mac    = ld_mac_q;
  assign data_outw = outw_q;
  assign data_outx = outx_q;

endmodule
